// File: rtl/eth_tx_framer_if.sv
// rtl/eth_tx_framer_if.sv - payload byte stream feeding eth_tx_framer
interface eth_tx_framer_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic [15:0] s_type_len;
  logic        s_ready;

  modport master (output s_data, s_valid, s_last, s_type_len, input s_ready);
  modport slave  (input s_data, s_valid, s_last, s_type_len, output s_ready);
endinterface

// File: rtl/eth_tx_framer.sv
// rtl/eth_tx_framer.sv - GMII transmit framer: preamble, MACs, type, payload, pad, FCS, IFG
// Define ETH_TX_VLAN_EN to insert an 802.1Q tag after the source MAC.
module eth_tx_framer #(
  parameter logic [47:0] DEST_MAC    = 48'h023528fbdd66,
  parameter logic [47:0] SRC_MAC     = 48'h072227acdb65,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          IFG_BYTES   = 12,
  parameter logic [15:0] VLAN_TCI    = 16'h0001
) (
  input  logic              clk,
  input  logic              rst,
  eth_tx_framer_if.slave    s_if,
  output logic [7:0]        gmii_data_out,
  output logic              gmii_en,
  output logic              gmii_er,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int CW = $clog2(MAX_PAYLOAD + 2);
`ifdef ETH_TX_VLAN_EN
  localparam int PAD_TARGET = MIN_PAYLOAD - 4;
`else
  localparam int PAD_TARGET = MIN_PAYLOAD;
  logic [15:0] unused_vlan_tci;
  assign unused_vlan_tci = VLAN_TCI;
`endif
  localparam logic [CW-1:0] PAD_CNT  = CW'(PAD_TARGET);
  localparam logic [CW-1:0] OVER_CNT = CW'(MAX_PAYLOAD + 1);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DEST, S_SRC,
`ifdef ETH_TX_VLAN_EN
    S_VLAN,
`endif
    S_TYPE, S_PAYLOAD, S_PAD, S_FCS, S_IFG, S_DROP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   crc_q, crc_d, fcs;
  logic [15:0]   type_q, type_d;
  logic [7:0]    data_q, data_d;
  logic          en_q, en_d, er_q, er_d, done_q, done_d, err_q, err_d;
  logic          ready_q, ready_d, busy_q, busy_d, crc_en;
  logic [2:0]    idx;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd0:    b = m[47:40];
      3'd1:    b = m[39:32];
      3'd2:    b = m[31:24];
      3'd3:    b = m[23:16];
      3'd4:    b = m[15:8];
      default: b = m[7:0];
    endcase
    return b;
  endfunction

  assign cnt_inc = cnt_q + CW'(1);
  assign idx     = cnt_q[2:0];
  assign fcs     = ~crc_q;

  // Each state computes the byte that appears on the pins in the following cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    type_d  = type_q;
    data_d  = 8'h00;
    en_d    = 1'b0;
    er_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    crc_en  = 1'b0;
    case (state_q)
      S_IDLE: if (s_if.s_valid) begin
        state_d = S_PRE;
        cnt_d   = CW'(1);
        crc_d   = 32'hFFFF_FFFF;
        type_d  = s_if.s_type_len;
        en_d    = 1'b1;
        data_d  = 8'h55;
      end
      S_PRE: begin
        en_d   = 1'b1;
        data_d = 8'h55;
        if (cnt_q == CW'(6)) begin state_d = S_SFD; cnt_d = '0; end
        else cnt_d = cnt_inc;
      end
      S_SFD: begin
        en_d    = 1'b1;
        data_d  = 8'hD5;
        state_d = S_DEST;
      end
      S_DEST: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        data_d = mac_byte(DEST_MAC, idx);
        if (cnt_q == CW'(5)) begin state_d = S_SRC; cnt_d = '0; end
        else cnt_d = cnt_inc;
      end
      S_SRC: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        data_d = mac_byte(SRC_MAC, idx);
        if (cnt_q == CW'(5)) begin
`ifdef ETH_TX_VLAN_EN
          state_d = S_VLAN;
`else
          state_d = S_TYPE;
`endif
          cnt_d = '0;
        end else cnt_d = cnt_inc;
      end
`ifdef ETH_TX_VLAN_EN
      S_VLAN: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        case (idx)
          3'd0:    data_d = 8'h81;
          3'd1:    data_d = 8'h00;
          3'd2:    data_d = VLAN_TCI[15:8];
          default: data_d = VLAN_TCI[7:0];
        endcase
        if (cnt_q == CW'(3)) begin state_d = S_TYPE; cnt_d = '0; end
        else cnt_d = cnt_inc;
      end
`endif
      S_TYPE: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        data_d = (idx == 3'd0) ? type_q[15:8] : type_q[7:0];
        if (cnt_q == CW'(1)) begin state_d = S_PAYLOAD; cnt_d = '0; end
        else cnt_d = cnt_inc;
      end
      S_PAYLOAD: begin
        en_d = 1'b1;
        if (!s_if.s_valid) begin
          er_d    = 1'b1;
          err_d   = 1'b1;
          state_d = S_DROP;
          cnt_d   = '0;
        end else begin
          data_d = s_if.s_data;
          crc_en = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == OVER_CNT) begin
            // A last byte arriving on the oversize byte ends the frame itself, so skip DROP.
            er_d    = 1'b1;
            err_d   = 1'b1;
            state_d = s_if.s_last ? S_IFG : S_DROP;
            cnt_d   = '0;
          end else if (s_if.s_last) begin
            if (cnt_inc < PAD_CNT) state_d = S_PAD;
            else begin state_d = S_FCS; cnt_d = '0; end
          end
        end
      end
      S_PAD: begin
        en_d   = 1'b1;
        crc_en = 1'b1;
        if (cnt_inc == PAD_CNT) begin state_d = S_FCS; cnt_d = '0; end
        else cnt_d = cnt_inc;
      end
      S_FCS: begin
        en_d = 1'b1;
        case (idx)
          3'd0:    data_d = fcs[7:0];
          3'd1:    data_d = fcs[15:8];
          3'd2:    data_d = fcs[23:16];
          default: data_d = fcs[31:24];
        endcase
        if (cnt_q == CW'(3)) begin
          state_d = S_IFG;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else cnt_d = cnt_inc;
      end
      S_IFG: begin
        if (cnt_q == IFG_LAST) begin state_d = S_IDLE; cnt_d = '0; end
        else cnt_d = cnt_inc;
      end
      S_DROP: if (s_if.s_valid && s_if.s_last) begin
        state_d = S_IFG;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    if (crc_en) crc_d = crc_byte(crc_q, data_d);
    ready_d = (state_d == S_PAYLOAD) || (state_d == S_DROP);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      crc_q   <= 32'hFFFF_FFFF;
      type_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      type_q  <= type_d;
      data_q  <= data_d;
      en_q    <= en_d;
      er_q    <= er_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign s_if.s_ready  = ready_q;
  assign gmii_data_out = data_q;
  assign gmii_en       = en_q;
  assign gmii_er       = er_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// tb/tb_eth_tx_framer.sv - table-driven bench for eth_tx_framer
module tb_eth_tx_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_tx_framer_if s_if();
  logic [7:0] gmii_data_out;
  logic       gmii_en, gmii_er, busy, frame_done, frame_err;

  eth_tx_framer dut (
    .clk(clk), .rst(rst), .s_if(s_if),
    .gmii_data_out(gmii_data_out), .gmii_en(gmii_en), .gmii_er(gmii_er),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

`ifdef ETH_TX_VLAN_EN
  localparam int VX = 4;
`else
  localparam int VX = 0;
`endif
  localparam int PADT = 46 - VX;
  localparam logic [47:0] DMAC = 48'h023528fbdd66;
  localparam logic [47:0] SMAC = 48'h072227acdb65;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Line monitor: cumulative counters, sampled on the falling edge.
  logic [7:0] cap[$];
  int en_total = 0, done_total = 0, err_total = 0, er_total = 0, er_pos = 0;
  int inv_bad = 0, gap_run = 0, last_gap = 0;
  always @(negedge clk) begin
    if (gmii_en) begin
      cap.push_back(gmii_data_out);
      en_total++;
      if (gap_run > 0) last_gap = gap_run;
      gap_run = 0;
    end else begin
      gap_run++;
      if (gmii_data_out != 8'h00 || gmii_er || frame_done) inv_bad++;
    end
    if (gmii_er) begin er_total++; er_pos = en_total; end
    if (frame_done) done_total++;
    if (frame_err) err_total++;
  end

  function automatic logic [31:0] m_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  logic [7:0] exp_q[$];
  task automatic build_exp(input int len, input logic [15:0] tl, input int under, input int seed);
    logic [47:0] dm, sm;
    logic [31:0] c;
    int n;
    dm = DMAC;
    sm = SMAC;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) exp_q.push_back(dm[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_q.push_back(sm[47-8*i -: 8]);
`ifdef ETH_TX_VLAN_EN
    exp_q.push_back(8'h81); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01);
`endif
    exp_q.push_back(tl[15:8]);
    exp_q.push_back(tl[7:0]);
    if (under >= 0) begin
      for (int i = 0; i < under; i++) exp_q.push_back(8'(i + seed));
      exp_q.push_back(8'h00);
    end else if (len > 1500) begin
      for (int i = 0; i < 1501; i++) exp_q.push_back(8'(i + seed));
    end else begin
      for (int i = 0; i < len; i++) exp_q.push_back(8'(i + seed));
      n = len;
      while (n < PADT) begin exp_q.push_back(8'h00); n++; end
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < exp_q.size(); i++) c = m_crc(c, exp_q[i]);
      c = ~c;
      for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    end
  endtask

  task automatic send_frame(input int len, input logic [15:0] tl, input int under,
                            input int seed, input int rst_at);
    int  i = 0, cyc = 0;
    bit  ud = 0, acc;
    s_if.s_type_len = tl;
    while (i < len) begin
      if (cyc > len * 3 + 400) begin chk("send_timeout", 1, 0); break; end
      if (rst_at >= 0 && i == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_en", gmii_en, 0);
        chk("rst_mid_data", gmii_data_out, 0);
        chk("rst_mid_er", gmii_er, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", s_if.s_ready, 0);
        chk("rst_mid_err", frame_err, 0);
        rst = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_last = 1'b0;
        return;
      end
      if (under >= 0 && i == under && !ud && s_if.s_ready) begin
        s_if.s_valid = 1'b0;
        ud = 1;
        @(posedge clk); #1;
        cyc++;
        continue;
      end
      s_if.s_valid = 1'b1;
      s_if.s_data  = 8'(i + seed);
      s_if.s_last  = (i == len - 1);
      @(negedge clk);
      acc = s_if.s_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) i++;
    end
    s_if.s_valid = 1'b0;
    s_if.s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 4000) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          len;
    logic [15:0] tl;
    int          under;
    int          exp_en;
    int          exp_done;
    int          exp_err;
  } vec_t;
  vec_t tv[9];

  initial begin
    int e0, d0, r0, x0, b0, c0, mism;
    logic [31:0] res;

    tv[0] = '{46,   16'h0800, -1, 72 + VX,   1, 0};
    tv[1] = '{10,   16'h0806, -1, 72,        1, 0};
    tv[2] = '{1,    16'h88B5, -1, 72,        1, 0};
    tv[3] = '{45,   16'h0801, -1, (VX != 0) ? 75 : 72, 1, 0};
    tv[4] = '{60,   16'h86DD, -1, 86 + VX,   1, 0};
    tv[5] = '{1500, 16'h0800, -1, 1526 + VX, 1, 0};
    tv[6] = '{40,   16'h0800, 19, 42 + VX,   0, 1};
    tv[7] = '{1501, 16'h0800, -1, 1523 + VX, 0, 1};
    tv[8] = '{1600, 16'h0800, -1, 1523 + VX, 0, 1};

    s_if.s_data = 8'h00;
    s_if.s_valid = 1'b0;
    s_if.s_last = 1'b0;
    s_if.s_type_len = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_en", gmii_en, 0);
    chk("reset_data", gmii_data_out, 0);
    chk("reset_er", gmii_er, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", s_if.s_ready, 0);
    chk("reset_done", frame_done, 0);
    chk("reset_err", frame_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      e0 = en_total; d0 = done_total; r0 = err_total;
      x0 = er_total; b0 = inv_bad;   c0 = cap.size();
      send_frame(tv[v].len, tv[v].tl, tv[v].under, v * 17, -1);
      wait_idle();
      chk($sformatf("v%0d_en_cycles", v), en_total - e0, tv[v].exp_en);
      chk($sformatf("v%0d_done", v), done_total - d0, tv[v].exp_done);
      chk($sformatf("v%0d_err", v), err_total - r0, tv[v].exp_err);
      chk($sformatf("v%0d_er_count", v), er_total - x0, tv[v].exp_err);
      chk($sformatf("v%0d_idle_line", v), inv_bad - b0, 0);
      build_exp(tv[v].len, tv[v].tl, tv[v].under, v * 17);
      chk($sformatf("v%0d_model_len", v), cap.size() - c0, exp_q.size());
      mism = 0;
      for (int k = 0; k < exp_q.size() && c0 + k < cap.size(); k++)
        if (cap[c0 + k] !== exp_q[k]) mism++;
      chk($sformatf("v%0d_bytes", v), mism, 0);
      if (tv[v].exp_done == 1 && cap.size() >= c0 + tv[v].exp_en) begin
        res = 32'hFFFF_FFFF;
        for (int k = c0 + 8; k < c0 + tv[v].exp_en; k++) res = m_crc(res, cap[k]);
        chk($sformatf("v%0d_fcs_residue", v), res, 32'hDEBB20E3);
      end
      if (tv[v].exp_err == 1) chk($sformatf("v%0d_er_pos", v), er_pos, e0 + tv[v].exp_en);
    end

    // Back-to-back frames with s_valid held high: exactly 12 idle cycles between them.
    e0 = en_total; d0 = done_total;
    send_frame(10, 16'h0800, -1, 5, -1);
    send_frame(10, 16'h0800, -1, 9, -1);
    wait_idle();
    chk("b2b_gap", last_gap, 12);
    chk("b2b_done", done_total - d0, 2);
    chk("b2b_en_cycles", en_total - e0, 144);

    // Reset part way through the payload, then a clean frame afterwards.
    d0 = done_total;
    send_frame(30, 16'h0800, -1, 3, 5);
    e0 = en_total;
    repeat (5) @(negedge clk);
    chk("rst_quiet_en", en_total - e0, 0);
    chk("rst_quiet_busy", busy, 0);
    chk("rst_no_done", done_total - d0, 0);
    @(posedge clk); #1;
    e0 = en_total; d0 = done_total; c0 = cap.size();
    send_frame(10, 16'h0806, -1, 1, -1);
    wait_idle();
    chk("recover_done", done_total - d0, 1);
    chk("recover_en_cycles", en_total - e0, 72);
    build_exp(10, 16'h0806, -1, 1);
    mism = 0;
    for (int k = 0; k < exp_q.size() && c0 + k < cap.size(); k++)
      if (cap[c0 + k] !== exp_q[k]) mism++;
    chk("recover_bytes", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
